// File: rtl/au_incdec_counter.sv
// Parametrised up/down range counter (0..LIMIT) with wrap/saturate modes, built on a
// prefix-AND incrementer whose decrement path inverts the operand around the same chain.
module au_incdec_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ARCH  = 0,
  parameter int unsigned LIMIT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             inc_dec,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ovf,
  output logic             tc_hi,
  output logic             tc_lo
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] pre;
  logic [WIDTH:0]   cvec;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] ld_val;
  logic             raw_co;
  logic             at_bnd;
  logic             bnd_step;

  assign opnd = inc_dec ? ~q : q;

  // pre[i] = &opnd[i:0]; the three architectures differ only in how the prefix tree is built.
  generate
    if (ARCH == 1) begin : g_sklansky
      logic [WIDTH-1:0] t;
      always_comb begin
        t = opnd;
        for (int unsigned l = 0; (32'd1 << l) < WIDTH; l++) begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (((i >> l) & 32'd1) == 32'd1) t[i] = t[i] & t[((i >> l) << l) - 32'd1];
          end
        end
        pre = t;
      end
    end else if (ARCH == 2) begin : g_kogge_stone
      logic [WIDTH-1:0] t;
      logic [WIDTH-1:0] nx;
      always_comb begin
        t  = opnd;
        nx = opnd;
        for (int unsigned l = 0; (32'd1 << l) < WIDTH; l++) begin
          nx = t;
          for (int unsigned i = (32'd1 << l); i < WIDTH; i++) begin
            nx[i] = t[i] & t[i - (32'd1 << l)];
          end
          t = nx;
        end
        pre = t;
      end
    end else begin : g_serial
      logic acc;
      always_comb begin
        acc = 1'b1;
        pre = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          acc    = acc & opnd[i];
          pre[i] = acc;
        end
      end
    end
  endgenerate

  // Carry-in tied high: carry into bit i is the prefix AND of all lower bits.
  assign cvec     = {pre, 1'b1};
  assign sum      = opnd ^ cvec[WIDTH-1:0];
  assign raw_co   = cvec[WIDTH];
  assign step_val = inc_dec ? ~sum : sum;

  // On the decrement path the raw carry of the inverted operand is exactly q==0;
  // the increment path must use the LIMIT compare since LIMIT may be below 2**WIDTH-1.
  assign at_bnd   = inc_dec ? raw_co : (q == LIM);
  assign bnd_step = en && !clr && !ld && at_bnd;
  assign ld_val   = (d > LIM) ? LIM : d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      co <= 1'b0;
      if (clr) begin
        q <= '0;
      end else if (ld) begin
        q <= ld_val;
      end else if (en) begin
        if (at_bnd) begin
          co <= 1'b1;
          if (!sat) q <= inc_dec ? LIM : '0;
        end else begin
          q <= step_val;
        end
      end
      if (bnd_step) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign tc_hi = (q == LIM);
  assign tc_lo = (q == '0);

endmodule

// File: tb/tb_au_incdec_counter.sv
// Bench for au_incdec_counter: five configurations driven in parallel against an
// arithmetic reference model, with directed boundary scenarios on the WIDTH=4/LIMIT=9 instance.
module tb_au_incdec_counter;

  logic       clk = 1'b0;
  logic       rst_n, clr, ld, en, inc_dec, sat, ovf_clr;
  logic [7:0] d8;

  logic [3:0] q_a;
  logic [7:0] q_b, q_c, q_d;
  logic [0:0] q_e;
  logic [4:0] co_v, ovf_v, thi_v, tlo_v;
  logic [7:0] dq [5];

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned lim  [5] = '{9, 255, 255, 255, 1};
  int unsigned mask [5] = '{15, 255, 255, 255, 1};
  int unsigned mq   [5];
  bit          mco  [5];
  bit          movf [5];

  always #5 clk = ~clk;

  au_incdec_counter #(.WIDTH(4), .ARCH(0), .LIMIT(9)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d8[3:0]), .en(en), .inc_dec(inc_dec),
    .sat(sat), .ovf_clr(ovf_clr), .q(q_a), .co(co_v[0]), .ovf(ovf_v[0]), .tc_hi(thi_v[0]), .tc_lo(tlo_v[0]));
  au_incdec_counter #(.WIDTH(8), .ARCH(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d8), .en(en), .inc_dec(inc_dec),
    .sat(sat), .ovf_clr(ovf_clr), .q(q_b), .co(co_v[1]), .ovf(ovf_v[1]), .tc_hi(thi_v[1]), .tc_lo(tlo_v[1]));
  au_incdec_counter #(.WIDTH(8), .ARCH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d8), .en(en), .inc_dec(inc_dec),
    .sat(sat), .ovf_clr(ovf_clr), .q(q_c), .co(co_v[2]), .ovf(ovf_v[2]), .tc_hi(thi_v[2]), .tc_lo(tlo_v[2]));
  au_incdec_counter #(.WIDTH(8), .ARCH(2)) u_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d8), .en(en), .inc_dec(inc_dec),
    .sat(sat), .ovf_clr(ovf_clr), .q(q_d), .co(co_v[3]), .ovf(ovf_v[3]), .tc_hi(thi_v[3]), .tc_lo(tlo_v[3]));
  au_incdec_counter #(.WIDTH(1), .ARCH(1), .LIMIT(1)) u_e (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d8[0:0]), .en(en), .inc_dec(inc_dec),
    .sat(sat), .ovf_clr(ovf_clr), .q(q_e), .co(co_v[4]), .ovf(ovf_v[4]), .tc_hi(thi_v[4]), .tc_lo(tlo_v[4]));

  assign dq[0] = {4'b0, q_a};
  assign dq[1] = q_b;
  assign dq[2] = q_c;
  assign dq[3] = q_d;
  assign dq[4] = {7'b0, q_e};

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      mq[k] = 0; mco[k] = 1'b0; movf[k] = 1'b0;
    end
  endtask

  // One clock of the reference: plain range arithmetic over 0..lim.
  task automatic model_tick();
    for (int k = 0; k < 5; k++) begin
      int unsigned dv;
      bit bnd;
      dv  = d8 & mask[k];
      bnd = 1'b0;
      if (clr) begin
        mq[k] = 0; mco[k] = 1'b0;
      end else if (ld) begin
        mq[k] = (dv > lim[k]) ? lim[k] : dv; mco[k] = 1'b0;
      end else if (en) begin
        if (!inc_dec) begin
          if (mq[k] == lim[k]) begin bnd = 1'b1; if (!sat) mq[k] = 0; end
          else mq[k] = mq[k] + 1;
        end else begin
          if (mq[k] == 0) begin bnd = 1'b1; if (!sat) mq[k] = lim[k]; end
          else mq[k] = mq[k] - 1;
        end
        mco[k] = bnd;
      end else begin
        mco[k] = 1'b0;
      end
      if (bnd) movf[k] = 1'b1;
      else if (ovf_clr) movf[k] = 1'b0;
    end
  endtask

  task automatic idle();
    clr = 0; ld = 0; en = 0; inc_dec = 0; sat = 0; ovf_clr = 0; d8 = '0;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({dq[0], co_v[0], ovf_v[0], tlo_v[0], thi_v[0]} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got q=%0d co=%b ovf=%b tc_lo=%b tc_hi=%b expected q=0 co=0 ovf=0 tc_lo=1 tc_hi=0",
               dq[0], co_v[0], ovf_v[0], tlo_v[0], thi_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_async_reset();
    idle();
    en = 1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (dq[0] !== 8'd5) begin
      n_fail++; $display("FAIL count_to_5: got q=%0d expected 5", dq[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dq[0], co_v[0], ovf_v[0], tlo_v[0]} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got q=%0d co=%b ovf=%b tc_lo=%b expected q=0 co=0 ovf=0 tc_lo=1",
               dq[0], co_v[0], ovf_v[0], tlo_v[0]);
    end
    en = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_q [3] = '{9, 0, 1};
    logic       exp_c [3] = '{0, 1, 0};
    logic       exp_o [3] = '{0, 1, 1};
    logic       exp_h [3] = '{1, 0, 0};
    idle();
    ld = 1; d8 = 8;
    step();
    ld = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({dq[0], co_v[0], ovf_v[0], thi_v[0]} !== {exp_q[i], exp_c[i], exp_o[i], exp_h[i]}) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got q=%0d co=%b ovf=%b tc_hi=%b expected q=%0d co=%b ovf=%b tc_hi=%b",
                 i, dq[0], co_v[0], ovf_v[0], thi_v[0], exp_q[i], exp_c[i], exp_o[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_wrap_down_sat();
    logic [7:0] exp_q [5] = '{0, 9, 0, 0, 0};
    logic       exp_c [5] = '{0, 1, 0, 1, 1};
    logic       exp_o [5] = '{0, 1, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin clr = 1; ovf_clr = 1; end
        1: begin en = 1; inc_dec = 1; end
        2: begin ld = 1; d8 = 0; end
        default: begin en = 1; inc_dec = 1; sat = 1; end
      endcase
      step();
      n_cmp++;
      if ({dq[0], co_v[0], ovf_v[0]} !== {exp_q[i], exp_c[i], exp_o[i]}) begin
        n_fail++;
        $display("FAIL wrap_down_sat[%0d]: got q=%0d co=%b ovf=%b expected q=%0d co=%b ovf=%b",
                 i, dq[0], co_v[0], ovf_v[0], exp_q[i], exp_c[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    logic [7:0] exp_q [3] = '{9, 0, 3};
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin ld = 1; d8 = 14; end
        1: begin clr = 1; ld = 1; en = 1; d8 = 14; end
        default: begin ld = 1; en = 1; d8 = 3; end
      endcase
      step();
      n_cmp++;
      if ({dq[0], co_v[0]} !== {exp_q[i], 1'b0}) begin
        n_fail++;
        $display("FAIL load_priority[%0d]: got q=%0d co=%b expected q=%0d co=0", i, dq[0], co_v[0], exp_q[i]);
      end
    end
    n_cmp++;
    if (dq[1] !== 8'd3) begin
      n_fail++; $display("FAIL load_no_step_w8: got q=%0d expected 3", dq[1]);
    end
  endtask

  task automatic test_ovf();
    logic [7:0] exp_q [3] = '{9, 0, 0};
    logic       exp_c [3] = '{0, 1, 0};
    logic       exp_o [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin ld = 1; d8 = 9; end
        1: begin en = 1; ovf_clr = 1; end
        default: ovf_clr = 1;
      endcase
      step();
      n_cmp++;
      if ({dq[0], co_v[0], ovf_v[0]} !== {exp_q[i], exp_c[i], exp_o[i]}) begin
        n_fail++;
        $display("FAIL ovf_handling[%0d]: got q=%0d co=%b ovf=%b expected q=%0d co=%b ovf=%b",
                 i, dq[0], co_v[0], ovf_v[0], exp_q[i], exp_c[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_full_range();
    idle();
    clr = 1;
    step();
    clr = 0; en = 1; inc_dec = 1;
    step();
    for (int k = 1; k < 4; k++) begin
      n_cmp++;
      if ({dq[k], co_v[k]} !== {8'd255, 1'b1}) begin
        n_fail++; $display("FAIL full_dec_wrap dut%0d: got q=%0d co=%b expected q=255 co=1", k, dq[k], co_v[k]);
      end
    end
    inc_dec = 0;
    step();
    for (int k = 1; k < 4; k++) begin
      n_cmp++;
      if ({dq[k], co_v[k]} !== {8'd0, 1'b1}) begin
        n_fail++; $display("FAIL full_inc_wrap dut%0d: got q=%0d co=%b expected q=0 co=1", k, dq[k], co_v[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clr     = ($urandom_range(0, 39) == 0);
      ld      = ($urandom_range(0, 14) == 0);
      d8      = 8'($urandom);
      en      = ($urandom_range(0, 3) != 0);
      inc_dec = ($urandom_range(0, 1) == 1);
      sat     = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 9) == 0);
      step();
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if ({dq[k], co_v[k], ovf_v[k], thi_v[k], tlo_v[k]} !==
            {8'(mq[k]), mco[k], movf[k], (mq[k] == lim[k]), (mq[k] == 0)}) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got q=%0d co=%b ovf=%b hi=%b lo=%b expected q=%0d co=%b ovf=%b hi=%b lo=%b",
                   k, c, dq[k], co_v[k], ovf_v[k], thi_v[k], tlo_v[k],
                   mq[k], mco[k], movf[k], (mq[k] == lim[k]), (mq[k] == 0));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_async_reset();
    test_wrap_up();
    test_wrap_down_sat();
    test_load_priority();
    test_ovf();
    test_full_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
